// File: rtl/fwft_small_fifo_pkg.sv
// Shared constants for the FWFT staging FIFO: default word layout and depth.
package fwft_small_fifo_pkg;
  localparam int unsigned CTRL_WIDTH         = 8;
  localparam int unsigned DATA_WIDTH         = 64;
  localparam int unsigned DEF_WIDTH          = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned DEF_MAX_DEPTH_BITS = 3;
endpackage

// File: rtl/fwft_small_fifo_mem_dp.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem_dp
  import fwft_small_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH_BITS = DEF_MAX_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [DEPTH_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);
  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the FIFO count.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fwft_small_fifo.sv
// First-word-fall-through FIFO: head word is always on dout while not empty,
// rd_en pops it. Flags decode the registered word count.
module fwft_small_fifo
  import fwft_small_fifo_pkg::*;
#(
  parameter int unsigned WIDTH               = DEF_WIDTH,
  parameter int unsigned MAX_DEPTH_BITS      = DEF_MAX_DEPTH_BITS,
  parameter int unsigned PROG_FULL_THRESHOLD = 2 ** MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);
  localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      w_rd_eff;
  logic                      w_wr_acc;
  logic [WIDTH-1:0]          w_head;

  // A write into a full FIFO is accepted only when the head is popped alongside.
  assign w_rd_eff = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_eff);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
      if (w_rd_eff) r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_eff);
`ifdef FWFT_SMALL_FIFO_SIM_MSGS
      if (wr_en && full && !w_rd_eff) $warning("fwft_small_fifo: write dropped, FIFO full");
      if (rd_en && empty) $warning("fwft_small_fifo: read ignored, FIFO empty");
`endif
    end
  end

  fifo_mem_dp #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (MAX_DEPTH_BITS)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  assign empty       = (r_count == '0);
  assign full        = (r_count == CW'(DEPTH));
  assign nearly_full = (r_count >= CW'(DEPTH - 1));
  assign prog_full   = (32'(r_count) >= PROG_FULL_THRESHOLD);
  assign dout        = empty ? '0 : w_head;
endmodule

// File: tb/tb_fwft_small_fifo.sv
// Directed self-checking bench for fwft_small_fifo at default parameters.
module tb_fwft_small_fifo;
  localparam int unsigned W = 72;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full, nearly_full, prog_full, empty;

  int n_checks = 0;
  int n_err    = 0;

  fwft_small_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         wr;
    logic         rd;
    logic [W-1:0] d;
    logic         e_empty;
    logic         e_full;
    logic         e_nf;
    logic         e_pf;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  // Expected flags follow from the hand-tracked count (depth 8, threshold 7).
  function automatic vec_t mk(input logic r, input logic w, input logic rd,
                              input logic [W-1:0] d, input int cnt,
                              input logic [W-1:0] exp_dout);
    vec_t v;
    v.rst_n   = r;
    v.wr      = w;
    v.rd      = rd;
    v.d       = d;
    v.e_empty = (cnt == 0);
    v.e_full  = (cnt == 8);
    v.e_nf    = (cnt >= 7);
    v.e_pf    = (cnt >= 7);
    v.e_dout  = exp_dout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flags(input string nm, input logic e, input logic f,
                           input logic nf, input logic pf);
    chk({nm, ".empty"}, W'(empty), W'(e));
    chk({nm, ".full"}, W'(full), W'(f));
    chk({nm, ".nearly_full"}, W'(nearly_full), W'(nf));
    chk({nm, ".prog_full"}, W'(prog_full), W'(pf));
  endtask

  // Apply inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    reset = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] exp_w;
  int           cnt;
  logic         w, r;

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    // Reset, idle reads, fall-through, fill, overflow drop, drain.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, 0, '0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, 0, '0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b1, '0, 0, '0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 72'hAB_0000000000001234, 1, 72'hAB_0000000000001234));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1, 72'hAB_0000000000001234));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, '0, 0, '0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, W'(i), i, W'(1)));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, W'(9), 8, W'(1)));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, '0, 8 - k, (k < 8) ? W'(k + 1) : '0));

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk_flags(nm, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_nf, vecs[i].e_pf);
      chk({nm, ".dout"}, dout, vecs[i].e_dout);
    end

    // Simultaneous read and write while full.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, W'(8'hA0 + i));
    chk_flags("full_pre", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("full_pre.dout", dout, W'(8'hA1));
    step(1'b1, 1'b1, 1'b1, W'(8'h55));
    chk_flags("full_rw", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("full_rw.dout", dout, W'(8'hA2));
    for (int k = 0; k < 8; k++) begin
      exp_w = (k < 7) ? W'(8'hA2 + k) : W'(8'h55);
      chk($sformatf("full_drain%0d", k), dout, exp_w);
      step(1'b1, 1'b0, 1'b1, '0);
    end
    chk_flags("full_drained", 1'b1, 1'b0, 1'b0, 1'b0);

    // Simultaneous read and write while empty: write wins, read ignored.
    step(1'b1, 1'b1, 1'b1, W'(8'h66));
    chk_flags("empty_rw", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("empty_rw.dout", dout, W'(8'h66));
    step(1'b1, 1'b0, 1'b1, '0);
    chk_flags("empty_rw_pop", 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap-around with occupancy held in 1..3 against a queue model.
    q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_w = W'(72'h5A_0000000000000000) | W'(i);
      step(1'b1, 1'b1, 1'b0, exp_w);
      q.push_back(exp_w);
    end
    for (int i = 0; i < 20; i++) begin
      cnt = q.size();
      w = (cnt < 3) && ((i % 4) != 3);
      r = (cnt > 1) && ((i % 3) != 0);
      exp_w = W'(i * 37 + 5) | (W'(i) << 64);
      if (r) chk($sformatf("wrap_head%0d", i), dout, q[0]);
      step(1'b1, w, r, exp_w);
      if (r) void'(q.pop_front());
      if (w) q.push_back(exp_w);
      chk($sformatf("wrap_empty%0d", i), W'(empty), W'(q.size() == 0));
    end
    while (q.size() > 0) begin
      chk("wrap_drain", dout, q[0]);
      step(1'b1, 1'b0, 1'b1, '0);
      void'(q.pop_front());
    end
    chk_flags("wrap_done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream discards stored words, even with a write pending.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, W'(8'hC0 + i));
    chk("mid_pre.dout", dout, W'(8'hC0));
    step(1'b0, 1'b1, 1'b1, W'(8'hEE));
    chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_rst.dout", dout, '0);
    step(1'b1, 1'b1, 1'b0, W'(8'h77));
    chk_flags("mid_wr", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_wr.dout", dout, W'(8'h77));
    step(1'b1, 1'b0, 1'b1, '0);
    chk_flags("mid_pop", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_pop.dout", dout, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fwft_small_fifo.md
Name:
fwft_small_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO, a few words deep, used as the input and output staging buffer in packet-processing pipeline stages, for example ahead of and behind the firewall match logic.
- The head word is always presented on dout while the FIFO is not empty.
- rd_en acknowledges (pops) the presented word; it does not request new data.
- One clock domain; flags are computed from the stored-word count.

Parameters:
- WIDTH, default 72: data word width in bits (ctrl+data concatenation, e.g. 8+64).
- MAX_DEPTH_BITS, default 3: log2 of capacity; DEPTH = 2**MAX_DEPTH_BITS words.
- PROG_FULL_THRESHOLD, default 2**MAX_DEPTH_BITS-1: word count at or above which prog_full asserts.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write strobe, sampled at the rising edge.
- rd_en  in  1  pop strobe for the current head word.
- dout  out  WIDTH  head word, combinational from storage.
- full  out  1  count == DEPTH.
- nearly_full  out  1  count >= DEPTH-1.
- prog_full  out  1  count >= PROG_FULL_THRESHOLD.
- empty  out  1  count == 0.

Behaviour:
- Storage and counters:
  - Circular buffer of DEPTH words with write pointer, read pointer and count.
  - Pointers are MAX_DEPTH_BITS wide and wrap modulo DEPTH naturally.
  - Count is MAX_DEPTH_BITS+1 wide.
- Reset:
  - reset==0 at a rising edge: pointers=0, count=0.
  - Resulting outputs: empty=1, full=0, nearly_full=0, prog_full=0 (for a threshold >0), dout=0.
  - Reset overrides wr_en and rd_en in the same cycle.
  - Reset mid-stream discards all stored words.
  - Memory contents are not cleared.
- Write:
  - If wr_en=1 and (!full or an effective read occurs in the same cycle), din is stored at the write pointer and the write pointer increments.
  - A write while full with no read is ignored: data is dropped and state is unchanged.
  - Simulation-only: an error message is printed for a dropped write.
- Read:
  - An effective read is rd_en=1 and !empty; the read pointer increments.
  - rd_en while empty is ignored (no underflow); simulation-only warning.
- Fall-through:
  - dout = mem[read pointer] whenever !empty, and 0 when empty.
  - A word written at edge k appears on dout, with empty=0, immediately after edge k.
  - Write-to-visible latency is 1 cycle.
  - No same-cycle bypass: when empty with wr_en and rd_en both high, the write is accepted, the read is ignored, and count becomes 1.
  - After an effective read at edge k, dout shows the next word immediately after edge k.
- Count update per edge:
  - +1 for an accepted write only.
  - -1 for an effective read only.
  - Unchanged for both or neither.
  - Simultaneous read and write when full: both occur and full stays 1.
- Flags: all four are combinational decodes of the registered count, so they are glitch-free relative to clk. No registered early flags.
- Ordering is strictly FIFO, with no reordering across wrap-around of the pointers.
- Capacity is exactly DEPTH words.

Decomposition:
- Shared package holds only common constants: default WIDTH=72 (CTRL 8 + DATA 64) and default MAX_DEPTH_BITS=3. Nothing else needs sharing.
- One natural sub-module, fifo_mem_dp: simple dual-port register array with synchronous write and asynchronous read, parameterised by WIDTH and depth.
- Pointer, count and flag logic stays in fwft_small_fifo.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 two cycles, release.
  - Required: empty=1, full=0, nearly_full=0, prog_full=0, dout=0; rd_en=1 for 3 cycles leaves all outputs unchanged.
- Fall-through latency:
  - Stimulus: single write din=72'hAB_0000000000001234.
  - Required: next cycle empty=0 and dout=72'hAB_0000000000001234 with no rd_en; after one rd_en, empty=1 and dout=0.
- Fill to full (defaults):
  - Stimulus: write 1..8 on consecutive cycles.
  - Required: nearly_full and prog_full assert after the 7th write; full asserts after the 8th.
  - Required: a 9th write of value 9 is dropped; popping returns 1..8 in order, then empty=1.
- Simultaneous read and write:
  - When full with wr_en=rd_en=1 and din=8'h55: full stays 1, count stays 8, the popped word is the oldest, and 8'h55 is the last word read out.
  - When empty with wr_en=rd_en=1 and din=8'h66: the next cycle shows empty=0 and dout=8'h66.
- Wrap-around:
  - Stimulus: 20 interleaved write/read cycles with count held between 1 and 3.
  - Required: output sequence equals input sequence exactly.
- Reset mid-stream:
  - Stimulus: with 5 words stored, pulse reset=0 for one cycle.
  - Required: empty=1 and count 0 afterwards; a subsequent write of 8'h77 appears on dout alone.
